wave_sample_sequencer: RTL
==========================

// Module: wave_sample_sequencer
// PURPOSE
//  Sequences the shared waveform generators (sin/sawtooth/triangle/square-pulse) at a programmable sample rate.
//  Forwards phase/amplitude writes to the generators, issues next-data strobes on a rate tick, waits
//  for the selected generator's valid strobe and captures the sample. Sits between top-level pins/regs and generators.
// PARAMETERS
//  DATA_W   8   sample / config data width
//  DIV_W    16  sample-rate divider width
//  TMO_CYC  63  max cycles from gen_next_strobe_o to selected valid before timeout
// PORTS
//  clk_i               in  1         single clock, all logic on posedge
//  rst_i               in  1         reset, asynchronous, active-high
//  enable_i            in  1         run sample sequencing
//  divider_i           in  DIV_W     sample period = divider_i+1 clocks
//  wave_sel_i          in  2         00 square,01 triangle,10 sawtooth,11 sin
//  cfg_data_i          in  DATA_W    phase/amplitude write value
//  cfg_phase_strobe_i  in  1         write cfg_data_i as phase
//  cfg_amp_strobe_i    in  1         write cfg_data_i as amplitude
//  err_clr_i           in  1         clear sticky errors
//  wave_data_i         in  4*DATA_W  generator samples, index = wave_sel encoding
//  wave_valid_i        in  4         generator valid strobes, same indexing
//  gen_data_o          out DATA_W    phase/amplitude value to generators
//  gen_phase_strobe_o  out 1         1-cycle new-phase strobe
//  gen_amp_strobe_o    out 1         1-cycle new-amplitude strobe
//  gen_next_strobe_o   out 1         1-cycle next-data request
//  sample_o            out DATA_W    last captured sample (held)
//  sample_valid_o      out 1         1-cycle strobe, sample_o updated
//  busy_o              out 1         FSM not in IDLE/WAIT_TICK
//  overrun_o           out 1         sticky: tick while tick already pending
//  timeout_o           out 1         sticky: no valid within TMO_CYC
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, divider cnt 0, pending flags 0.
//  Divider: runs while enable_i; cleared when low. cnt>=divider_i -> tick, cnt<=0 (live compare;
//   divider_i=0 ticks every cycle). Tick sets tick_pend; tick with tick_pend already set -> overrun_o=1, tick lost.
//  Config: cfg strobe latches cfg_data_i into phase_pend/amp_pend (latest write wins), any state.
//   Both strobes same cycle -> both latched with same data.
//  FSM: IDLE -> WAIT_TICK when enable_i. WAIT_TICK: cfg pending -> CFG_PH/CFG_AMP (priority);
//   else tick_pend -> REQUEST; else !enable_i -> IDLE. IDLE also services pending cfg.
//   CFG_PH: gen_data_o=phase, gen_phase_strobe_o=1 one cycle; then CFG_AMP if amp pending, else back.
//   REQUEST: gen_next_strobe_o=1, clear tick_pend, latch wave_sel_i into sel_q -> WAIT_VALID.
//   WAIT_VALID: wave_valid_i[sel_q] at cycle V -> sample_o=wave_data_i[sel_q], sample_valid_o=1 at V+1;
//    TMO_CYC cycles w/o valid -> timeout_o=1, sample_o held, no strobe. Exit -> WAIT_TICK.
//  Latency: tick_pend set at T -> gen_next_strobe_o at T+1 (if no cfg pending).
//  wave_sel_i changes mid-sample ignored until next REQUEST. Valids of non-selected generators ignored.
//  enable_i low in WAIT_VALID: sample completes, then IDLE; tick_pend cleared on entry to IDLE.
//  err_clr_i clears sticky flags; simultaneous set event wins. rst_i mid-op aborts at once, no strobes.
// CONFIGURATION
//  SEQ_STATS_EN defined: adds sample_count_o out 16 (wraps 0xFFFF->0, +1 per sample_valid_o, cleared by err_clr_i).
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  wave_seq_pkg: FSM state enum, WAVE_SQUARE/TRI/SAW/SIN sel constants, default widths.
//  Sub-module rate_tick_divider (enable, divider, tick out); FSM + capture in this module.
// TESTING
//  divider_i=9, sel=11, sin valid 3 cyc after req -> gen_next every 10 clk, sample_o=sin data, 1 strobe each.
//  divider_i=0, valid delay 5 -> overrun_o=1, err_clr_i -> 0; sampling continues.
//  cfg phase 0x40+amp 0x7F same cycle as tick -> phase strobe, amp strobe, next strobe on 3 consecutive clks.
//  sel=01, drop triangle valid -> timeout_o=1 after 63 cyc, sample_o unchanged, no sample_valid_o.
//  wave_sel_i 11->10 during WAIT_VALID -> captured sample from sin; next sample from sawtooth.
//  rst_i mid WAIT_VALID -> all outputs 0 async; enable_i low during sample -> completes, then IDLE.

Source files
------------

// File: rtl/wave_seq_pkg.sv
// rtl/wave_seq_pkg.sv - shared types and constants for the waveform sample sequencer
package wave_seq_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int DIV_W_DEF   = 16;
  localparam int TMO_CYC_DEF = 63;

  localparam logic [1:0] WAVE_SQUARE = 2'b00;
  localparam logic [1:0] WAVE_TRI    = 2'b01;
  localparam logic [1:0] WAVE_SAW    = 2'b10;
  localparam logic [1:0] WAVE_SIN    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_CFG_PH,
    ST_CFG_AMP,
    ST_REQUEST,
    ST_WAIT_VALID
  } seq_state_t;

  function automatic logic is_busy(input seq_state_t s);
    return !(s == ST_IDLE || s == ST_WAIT_TICK);
  endfunction

endpackage

// File: rtl/rate_tick_divider.sv
// rtl/rate_tick_divider.sv - programmable sample-rate tick generator
module rate_tick_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] divider_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt;

  // Live compare so a divider lowered below the current count ticks at once.
  assign tick_o = enable_i && (cnt >= divider_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (!enable_i || tick_o) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wave_sample_sequencer.sv
// rtl/wave_sample_sequencer.sv - sequences waveform generators at a programmable rate
// Optional SEQ_STATS_EN adds the sample_count_o statistics counter.
module wave_sample_sequencer
  import wave_seq_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [DIV_W-1:0]  divider_i,
  input  logic [1:0]        wave_sel_i,
  input  logic [DATA_W-1:0] cfg_data_i,
  input  logic              cfg_phase_strobe_i,
  input  logic              cfg_amp_strobe_i,
  input  logic              err_clr_i,
  input  logic [4*DATA_W-1:0] wave_data_i,
  input  logic [3:0]        wave_valid_i,
  output logic [DATA_W-1:0] gen_data_o,
  output logic              gen_phase_strobe_o,
  output logic              gen_amp_strobe_o,
  output logic              gen_next_strobe_o,
  output logic [DATA_W-1:0] sample_o,
  output logic              sample_valid_o,
  output logic              busy_o,
  output logic              overrun_o,
  output logic              timeout_o
`ifdef SEQ_STATS_EN
  ,
  output logic [15:0]       sample_count_o
`endif
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  seq_state_t        state, state_d;
  logic              tick;
  logic              tick_pend, phase_pend, amp_pend;
  logic [DATA_W-1:0] phase_val, amp_val;
  logic [1:0]        sel_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              sel_valid, tmo_hit, ovr_hit;
  logic [DATA_W-1:0] sel_data;

  rate_tick_divider #(.DIV_W(DIV_W)) u_div (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .divider_i(divider_i),
    .tick_o   (tick)
  );

  assign sel_valid = wave_valid_i[sel_q];
  assign sel_data  = wave_data_i[int'(sel_q) * DATA_W +: DATA_W];
  assign tmo_hit   = (state == ST_WAIT_VALID) && !sel_valid && (tmo_cnt == TMO_LAST);
  // A tick landing in REQUEST re-arms the pending flag instead of overrunning.
  assign ovr_hit   = tick && tick_pend && (state != ST_REQUEST);

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (phase_pend)    state_d = ST_CFG_PH;
        else if (amp_pend) state_d = ST_CFG_AMP;
        else if (enable_i) state_d = ST_WAIT_TICK;
      end
      ST_WAIT_TICK, ST_CFG_PH, ST_CFG_AMP: begin
        if (phase_pend)     state_d = ST_CFG_PH;
        else if (amp_pend)  state_d = ST_CFG_AMP;
        else if (tick_pend) state_d = ST_REQUEST;
        else if (!enable_i) state_d = ST_IDLE;
        else                state_d = ST_WAIT_TICK;
      end
      ST_REQUEST: state_d = ST_WAIT_VALID;
      ST_WAIT_VALID: begin
        if (sel_valid || tmo_hit) state_d = enable_i ? ST_WAIT_TICK : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they coincide with state entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state              <= ST_IDLE;
      gen_data_o         <= '0;
      gen_phase_strobe_o <= 1'b0;
      gen_amp_strobe_o   <= 1'b0;
      gen_next_strobe_o  <= 1'b0;
      sample_o           <= '0;
      sample_valid_o     <= 1'b0;
      busy_o             <= 1'b0;
      overrun_o          <= 1'b0;
      timeout_o          <= 1'b0;
      tick_pend          <= 1'b0;
      phase_pend         <= 1'b0;
      amp_pend           <= 1'b0;
      phase_val          <= '0;
      amp_val            <= '0;
      sel_q              <= WAVE_SQUARE;
      tmo_cnt            <= '0;
    end else begin
      state              <= state_d;
      busy_o             <= is_busy(state_d);
      gen_phase_strobe_o <= (state_d == ST_CFG_PH);
      gen_amp_strobe_o   <= (state_d == ST_CFG_AMP);
      gen_next_strobe_o  <= (state_d == ST_REQUEST);
      sample_valid_o     <= 1'b0;

      if (state_d == ST_CFG_PH) begin
        gen_data_o <= phase_val;
        phase_pend <= 1'b0;
      end else if (state_d == ST_CFG_AMP) begin
        gen_data_o <= amp_val;
        amp_pend   <= 1'b0;
      end
      if (cfg_phase_strobe_i) begin
        phase_pend <= 1'b1;
        phase_val  <= cfg_data_i;
      end
      if (cfg_amp_strobe_i) begin
        amp_pend <= 1'b1;
        amp_val  <= cfg_data_i;
      end

      if (state_d == ST_IDLE)         tick_pend <= 1'b0;
      else if (tick)                  tick_pend <= 1'b1;
      else if (state == ST_REQUEST)   tick_pend <= 1'b0;

      if (state == ST_REQUEST) begin
        sel_q   <= wave_sel_i;
        tmo_cnt <= '0;
      end

      if (state == ST_WAIT_VALID) begin
        if (sel_valid) begin
          sample_o       <= sel_data;
          sample_valid_o <= 1'b1;
        end else if (!tmo_hit) begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end

      overrun_o <= (overrun_o && !err_clr_i) || ovr_hit;
      timeout_o <= (timeout_o && !err_clr_i) || tmo_hit;
    end
  end

`ifdef SEQ_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          sample_count_o <= '0;
    else if (err_clr_i) sample_count_o <= '0;
    else                sample_count_o <= sample_count_o + {15'd0, sample_valid_o};
  end
`endif

endmodule
